parking: RTL and testbench

// - Occupancy controller for a 700-space car park split into a university zone and a free (public) zone.
// - Tracks parked cars per zone and reports remaining spaces and vacancy flags.
// - Flags illegal entries (zone full) and illegal exits (zone empty).
// - An internal time-of-day counter moves capacity from the university zone to the free zone during the afternoon.
// - Sits between the gate sensors (one entry and one exit event per cycle) and the display/barrier logic.

---
 rtl/parking_if.sv | 29 ++
 rtl/parking.sv | 107 ++++++++++
 tb/tb_parking.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_if.sv
// Gate-sensor events in, occupancy/vacancy/status out for the car-park controller.
interface parking_if;
   localparam int unsigned CW = 9;

   logic          car_entered;
   logic          is_uni_car_entered;
   logic          car_exited;
   logic          is_uni_car_exited;
   logic [CW-1:0] uni_parked_car;
   logic [CW-1:0] parked_car;
   logic [CW-1:0] uni_vacated_space;
   logic [CW-1:0] vacated_space;
   logic          uni_is_vacated_space;
   logic          is_vacated_space;
   logic          illegal_enter;
   logic          illegal_exit;

   modport master (
      output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      input  uni_parked_car, parked_car, uni_vacated_space, vacated_space,
             uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit
   );

   modport slave (
      input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
      output uni_parked_car, parked_car, uni_vacated_space, vacated_space,
             uni_is_vacated_space, is_vacated_space, illegal_enter, illegal_exit
   );
endinterface

// File: rtl/parking.sv
// Two-zone car-park occupancy controller with a time-of-day capacity shift
// from the university zone to the free zone in the afternoon.
module parking #(
   parameter int unsigned TOTAL_CAP       = 700,
   parameter int unsigned CYCLES_PER_HOUR = 3600
) (
   input  logic     clk,
   input  logic     reset,
   parking_if.slave bus
);
   localparam int unsigned CW = 9;
   localparam int unsigned HW = 5;
   localparam int unsigned TW = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
   localparam logic [HW-1:0] HOUR_START = HW'(8);
   localparam logic [HW-1:0] HOUR_LAST  = HW'(23);

   logic [TW-1:0] tick_q, tick_d;
   logic [HW-1:0] hour_q, hour_d;
   logic [CW-1:0] uni_cnt_q, uni_cnt_d;
   logic [CW-1:0] free_cnt_q, free_cnt_d;
   logic          ill_en_q, ill_en_d;
   logic          ill_ex_q, ill_ex_d;

   logic [CW-1:0] free_cap, uni_cap, free_vac, uni_vac;
   logic          ent_ok, ext_ok;

   // Afternoon schedule: capacity migrates from the university zone to the free zone.
   always_comb begin
      free_cap = CW'(200);
      uni_cap  = CW'(TOTAL_CAP - 200);
      if (hour_q == HW'(13)) begin
         free_cap = CW'(250);
         uni_cap  = CW'(TOTAL_CAP - 250);
      end else if (hour_q == HW'(14)) begin
         free_cap = CW'(300);
         uni_cap  = CW'(TOTAL_CAP - 300);
      end else if (hour_q == HW'(15)) begin
         free_cap = CW'(350);
         uni_cap  = CW'(TOTAL_CAP - 350);
      end else if (hour_q >= HW'(16)) begin
         free_cap = CW'(500);
         uni_cap  = CW'(TOTAL_CAP - 500);
      end
   end

   // A shrinking capacity may leave more cars than spaces; vacancy clamps at zero.
   assign free_vac = (free_cnt_q >= free_cap) ? '0 : free_cap - free_cnt_q;
   assign uni_vac  = (uni_cnt_q  >= uni_cap)  ? '0 : uni_cap  - uni_cnt_q;

   always_comb begin
      tick_d = tick_q + TW'(1);
      hour_d = hour_q;
      if (tick_q == TW'(CYCLES_PER_HOUR - 1)) begin
         tick_d = '0;
         if (hour_q != HOUR_LAST) hour_d = hour_q + HW'(1);
      end
   end

   // Both events are judged against pre-edge state, so same-zone in+out nets to zero.
   always_comb begin
      ent_ok = bus.car_entered &&
               (bus.is_uni_car_entered ? (uni_vac != '0) : (free_vac != '0));
      ext_ok = bus.car_exited &&
               (bus.is_uni_car_exited ? (uni_cnt_q != '0) : (free_cnt_q != '0));

      uni_cnt_d  = uni_cnt_q;
      free_cnt_d = free_cnt_q;
      if (ent_ok) begin
         if (bus.is_uni_car_entered) uni_cnt_d  = uni_cnt_d  + CW'(1);
         else                        free_cnt_d = free_cnt_d + CW'(1);
      end
      if (ext_ok) begin
         if (bus.is_uni_car_exited) uni_cnt_d  = uni_cnt_d  - CW'(1);
         else                       free_cnt_d = free_cnt_d - CW'(1);
      end

      ill_en_d = bus.car_entered && !ent_ok;
      ill_ex_d = bus.car_exited  && !ext_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_q     <= '0;
         hour_q     <= HOUR_START;
         uni_cnt_q  <= '0;
         free_cnt_q <= '0;
         ill_en_q   <= 1'b0;
         ill_ex_q   <= 1'b0;
      end else begin
         tick_q     <= tick_d;
         hour_q     <= hour_d;
         uni_cnt_q  <= uni_cnt_d;
         free_cnt_q <= free_cnt_d;
         ill_en_q   <= ill_en_d;
         ill_ex_q   <= ill_ex_d;
      end
   end

   assign bus.uni_parked_car       = uni_cnt_q;
   assign bus.parked_car           = free_cnt_q;
   assign bus.uni_vacated_space    = uni_vac;
   assign bus.vacated_space        = free_vac;
   assign bus.uni_is_vacated_space = (uni_vac != '0);
   assign bus.is_vacated_space     = (free_vac != '0);
   assign bus.illegal_enter        = ill_en_q;
   assign bus.illegal_exit         = ill_ex_q;
endmodule

// File: tb/tb_parking.sv
// Self-checking bench for parking: directed scenarios plus randomized traffic
// checked against an occupancy model derived from the car-park rules.
module tb_parking;
   localparam int TOTAL = 700;
   localparam int CPH   = 3600;

   logic clk;
   logic reset;
   parking_if bus ();

   parking #(.TOTAL_CAP(TOTAL), .CYCLES_PER_HOUR(CPH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   int m_uni, m_free, m_cyc;
   bit m_ie, m_ix;

   function automatic int m_hour();
      int h;
      h = 8 + m_cyc / CPH;
      return (h > 23) ? 23 : h;
   endfunction

   function automatic int m_fcap();
      int h;
      h = m_hour();
      if (h < 13)  return 200;
      if (h == 13) return 250;
      if (h == 14) return 300;
      if (h == 15) return 350;
      return 500;
   endfunction

   function automatic int m_fvac();
      return (m_free >= m_fcap()) ? 0 : m_fcap() - m_free;
   endfunction

   function automatic int m_uvac();
      int uc;
      uc = TOTAL - m_fcap();
      return (m_uni >= uc) ? 0 : uc - m_uni;
   endfunction

   function automatic logic [39:0] exp_vec();
      return {9'(m_uni), 9'(m_free), 9'(m_uvac()), 9'(m_fvac()),
              m_uvac() != 0, m_fvac() != 0, m_ie, m_ix};
   endfunction

   function automatic logic [39:0] dut_vec();
      return {bus.uni_parked_car, bus.parked_car, bus.uni_vacated_space, bus.vacated_space,
              bus.uni_is_vacated_space, bus.is_vacated_space, bus.illegal_enter, bus.illegal_exit};
   endfunction

   task automatic model_reset();
      m_uni = 0; m_free = 0; m_cyc = 0; m_ie = 0; m_ix = 0;
   endtask

   // One clock with the given events; model advances on the same edge.
   task automatic step(input bit e, input bit ue, input bit x, input bit ux);
      bit ok_e, ok_x;
      bus.car_entered = e; bus.is_uni_car_entered = ue;
      bus.car_exited  = x; bus.is_uni_car_exited  = ux;
      @(posedge clk);
      ok_e = e && (ue ? (m_uvac() > 0) : (m_fvac() > 0));
      ok_x = x && (ux ? (m_uni > 0) : (m_free > 0));
      if (ok_e) begin if (ue) m_uni++; else m_free++; end
      if (ok_x) begin if (ux) m_uni--; else m_free--; end
      m_ie = e && !ok_e;
      m_ix = x && !ok_x;
      m_cyc++;
      #1;
      bus.car_entered = 0; bus.car_exited = 0;
   endtask

   task automatic test_reset();
      bus.car_entered = 0; bus.is_uni_car_entered = 0;
      bus.car_exited  = 0; bus.is_uni_car_exited  = 0;
      reset = 1'b1;
      #12;
      model_reset();
      n_chk++;
      if (dut_vec() !== {9'd0, 9'd0, 9'd500, 9'd200, 1'b1, 1'b1, 1'b0, 1'b0})
         $display("FAIL reset_state got=%h exp=%h", dut_vec(),
                  {9'd0, 9'd0, 9'd500, 9'd200, 1'b1, 1'b1, 1'b0, 1'b0});
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_fill_free();
      for (int i = 0; i < 256; i++) begin
         step(1, 0, 0, 0);
         n_chk++;
         if (bus.illegal_enter !== (i >= 200))
            $display("FAIL fill_illegal_enter attempt=%0d got=%b exp=%b", i + 1, bus.illegal_enter, i >= 200);
         else n_pass++;
      end
      n_chk++;
      if ({bus.parked_car, bus.vacated_space, bus.is_vacated_space} !== {9'd200, 9'd0, 1'b0})
         $display("FAIL fill_full got=%0d/%0d/%b exp=200/0/0", bus.parked_car, bus.vacated_space, bus.is_vacated_space);
      else n_pass++;
   endtask

   task automatic test_illegal_exit();
      step(0, 0, 1, 1);
      n_chk++;
      if ({bus.illegal_exit, bus.uni_parked_car, bus.parked_car} !== {1'b1, 9'd0, 9'd200})
         $display("FAIL uni_exit_empty got ix=%b uni=%0d free=%0d exp ix=1 uni=0 free=200",
                  bus.illegal_exit, bus.uni_parked_car, bus.parked_car);
      else n_pass++;
      step(0, 0, 0, 0);
      n_chk++;
      if (bus.illegal_exit !== 1'b0)
         $display("FAIL illegal_exit_clear got=%b exp=0", bus.illegal_exit);
      else n_pass++;
   endtask

   task automatic test_free_turnover();
      step(0, 0, 1, 0);
      n_chk++;
      if (bus.parked_car !== 9'd199) $display("FAIL free_exit got=%0d exp=199", bus.parked_car);
      else n_pass++;
      step(1, 0, 0, 0);
      n_chk++;
      if ({bus.parked_car, bus.illegal_enter} !== {9'd200, 1'b0})
         $display("FAIL free_reenter got=%0d ie=%b exp=200 ie=0", bus.parked_car, bus.illegal_enter);
      else n_pass++;
      step(1, 0, 0, 0);
      n_chk++;
      if ({bus.parked_car, bus.illegal_enter} !== {9'd200, 1'b1})
         $display("FAIL free_over got=%0d ie=%b exp=200 ie=1", bus.parked_car, bus.illegal_enter);
      else n_pass++;
   endtask

   task automatic test_uni_entry_exit();
      step(1, 1, 0, 0);
      n_chk++;
      if ({bus.uni_parked_car, bus.uni_vacated_space, bus.illegal_enter} !== {9'd1, 9'd499, 1'b0})
         $display("FAIL uni_entry got=%0d/%0d ie=%b exp=1/499 ie=0",
                  bus.uni_parked_car, bus.uni_vacated_space, bus.illegal_enter);
      else n_pass++;
      step(0, 0, 1, 1);
      n_chk++;
      if ({bus.uni_parked_car, bus.uni_vacated_space} !== {9'd0, 9'd500})
         $display("FAIL uni_exit got=%0d/%0d exp=0/500", bus.uni_parked_car, bus.uni_vacated_space);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      step(1, 1, 1, 1);
      n_chk++;
      if ({bus.uni_parked_car, bus.illegal_exit, bus.illegal_enter} !== {9'd1, 1'b1, 1'b0})
         $display("FAIL simul_empty got uni=%0d ix=%b ie=%b exp uni=1 ix=1 ie=0",
                  bus.uni_parked_car, bus.illegal_exit, bus.illegal_enter);
      else n_pass++;
      step(1, 1, 1, 1);
      n_chk++;
      if ({bus.uni_parked_car, bus.illegal_exit, bus.illegal_enter} !== {9'd1, 1'b0, 1'b0})
         $display("FAIL simul_one got uni=%0d ix=%b ie=%b exp uni=1 ix=0 ie=0",
                  bus.uni_parked_car, bus.illegal_exit, bus.illegal_enter);
      else n_pass++;
   endtask

   task automatic test_random(input string tag, input int n);
      int errs;
      errs = 0;
      for (int i = 0; i < n; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         n_chk++;
         if (dut_vec() !== exp_vec()) begin
            errs++;
            if (errs <= 5)
               $display("FAIL random_%s cyc=%0d got=%h exp=%h", tag, m_cyc, dut_vec(), exp_vec());
         end else n_pass++;
      end
   endtask

   task automatic run_to_hour(input int h);
      while (m_hour() < h) step(0, 0, 0, 0);
   endtask

   task automatic test_schedule();
      for (int i = 0; i < 600 && m_free < 200; i++) step(1, 0, 0, 0);
      for (int i = 0; i < 600 && m_uni != 300; i++) step(m_uni < 300, 1, m_uni > 300, 1);
      n_chk++;
      if ({bus.parked_car, bus.uni_parked_car} !== {9'd200, 9'd300})
         $display("FAIL sched_setup got free=%0d uni=%0d exp 200/300", bus.parked_car, bus.uni_parked_car);
      else n_pass++;
      run_to_hour(13);
      n_chk++;
      if ({bus.vacated_space, bus.uni_vacated_space} !== {9'd50, 9'd150})
         $display("FAIL hour13 got vac=%0d uvac=%0d exp 50/150", bus.vacated_space, bus.uni_vacated_space);
      else n_pass++;
      run_to_hour(16);
      n_chk++;
      if ({bus.vacated_space, bus.uni_vacated_space, bus.uni_is_vacated_space, bus.uni_parked_car}
          !== {9'd300, 9'd0, 1'b0, 9'd300})
         $display("FAIL hour16 got vac=%0d uvac=%0d uis=%b uni=%0d exp 300/0/0/300",
                  bus.vacated_space, bus.uni_vacated_space, bus.uni_is_vacated_space, bus.uni_parked_car);
      else n_pass++;
      step(1, 1, 0, 0);
      n_chk++;
      if ({bus.illegal_enter, bus.uni_parked_car} !== {1'b1, 9'd300})
         $display("FAIL hour16_uni_blocked got ie=%b uni=%0d exp 1/300", bus.illegal_enter, bus.uni_parked_car);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      model_reset();
      n_chk++;
      if (dut_vec() !== {9'd0, 9'd0, 9'd500, 9'd200, 1'b1, 1'b1, 1'b0, 1'b0})
         $display("FAIL mid_reset got=%h exp=%h", dut_vec(),
                  {9'd0, 9'd0, 9'd500, 9'd200, 1'b1, 1'b1, 1'b0, 1'b0});
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      test_random("after_reset", 200);
   endtask

   initial begin
      test_reset();
      test_fill_free();
      test_illegal_exit();
      test_free_turnover();
      test_uni_entry_exit();
      test_simultaneous();
      test_random("hour8", 1500);
      test_schedule();
      test_random("late", 1500);
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
